riscv_regfile_dump: RTL and testbench

RISCV_REGFILE_DUMP -- requirements
Module: riscv_regfile_dump

---
 rtl/riscv_regfile_dump_pkg.sv | 21 ++
 rtl/riscv_regfile_dump_fifo.sv | 64 ++++++
 rtl/riscv_regfile_dump.sv | 130 +++++++++++++
 tb/tb_riscv_regfile_dump.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_regfile_dump_pkg.sv
// Shared RISC-V sizing constants and the layout of one buffered dump word.
package riscv_regfile_dump_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_AW   = $clog2(NUM_REGS);

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } dump_entry_t;

  // Number of registers in an inclusive, wrapping index range (1..NUM_REGS).
  function automatic logic [REG_AW:0] range_len(input logic [REG_AW-1:0] first,
                                                input logic [REG_AW-1:0] last);
    logic [REG_AW-1:0] span;
    span = last - first;
    return {1'b0, span} + (REG_AW+1)'(1);
  endfunction

endpackage

// File: rtl/riscv_regfile_dump_fifo.sv
// Two-entry buffer between the regfile fetch and the dump consumer.
module riscv_regfile_dump_fifo
  import riscv_regfile_dump_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  dump_entry_t data_i,
  input  logic        pop_i,
  output dump_entry_t data_o,
  output logic        full_o,
  output logic        empty_o
);

  dump_entry_t mem0_q, mem0_d;
  dump_entry_t mem1_q, mem1_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        do_push, do_pop;

  // A push into a full buffer lands in the slot being popped this cycle.
  always_comb begin
    do_pop  = pop_i && (cnt_q != 2'd0);
    do_push = push_i && ((cnt_q != 2'd2) || do_pop);
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      if (wr_q) mem1_d = data_i;
      else      mem0_d = data_i;
      wr_d = ~wr_q;
    end
    if (do_pop) rd_d = ~rd_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem0_q <= '0;
      mem1_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o  = rd_q ? mem1_q : mem0_q;
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/riscv_regfile_dump.sv
// Walks an inclusive (wrapping) range of integer registers through the rs1
// read port and streams {index, value} words out over a valid/ready channel.
module riscv_regfile_dump
  import riscv_regfile_dump_pkg::*;
#(
  parameter bit P_SKIP_X0 = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_dump_start,
  input  logic [REG_AW-1:0] i_dump_first,
  input  logic [REG_AW-1:0] i_dump_last,
  output logic [REG_AW-1:0] o_regfile_rs1_addr,
  input  logic [XLEN-1:0]   i_regfile_rs1_data,
  output logic              o_dump_valid,
  input  logic              i_dump_ready,
  output logic [XLEN-1:0]   o_dump_data,
  output logic [REG_AW-1:0] o_dump_addr,
  output logic              o_dump_busy,
  output logic              o_dump_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [REG_AW-1:0] X0 = '0;

  logic [1:0]        state_q, state_d;
  logic [REG_AW-1:0] ptr_q, ptr_d;
  logic [REG_AW-1:0] rs1_addr_q, rs1_addr_d;
  logic [REG_AW:0]   remaining_q, remaining_d;
  logic              primed_q, primed_d;

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic        advance, skip, drain_last;
  dump_entry_t push_entry, head_entry;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (i_dump_start) state_d = S_FETCH;
      S_FETCH: if (remaining_d == '0) state_d = S_DRAIN;
      S_DRAIN: if (drain_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    o_dump_busy = 1'b0;
    o_dump_done = 1'b0;
    unique case (state_q)
      S_FETCH, S_DRAIN: o_dump_busy = 1'b1;
      S_DONE:           o_dump_done = 1'b1;
      default:          ;
    endcase
  end

  // Fetch pointer. The first FETCH cycle only settles the read address, so
  // every captured word comes from an address that was stable a full cycle.
  always_comb begin
    fifo_pop   = !fifo_empty && i_dump_ready;
    advance    = (state_q == S_FETCH) && primed_q && (remaining_q != '0);
    skip       = advance && P_SKIP_X0 && (ptr_q == X0);
    fifo_push  = advance && !skip && (!fifo_full || fifo_pop);
    drain_last = fifo_empty || (!fifo_full && fifo_pop);

    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    primed_d    = primed_q;
    rs1_addr_d  = rs1_addr_q;
    if ((state_q == S_IDLE) && i_dump_start) begin
      ptr_d       = i_dump_first;
      remaining_d = range_len(i_dump_first, i_dump_last);
      primed_d    = 1'b0;
      rs1_addr_d  = i_dump_first;
    end else if (state_q == S_FETCH) begin
      primed_d = 1'b1;
      if (skip || fifo_push) begin
        ptr_d       = ptr_q + REG_AW'(1);
        remaining_d = remaining_q - (REG_AW+1)'(1);
        if (remaining_q != (REG_AW+1)'(1)) rs1_addr_d = ptr_q + REG_AW'(1);
      end
    end

    push_entry.addr = ptr_q;
    push_entry.data = i_regfile_rs1_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q       <= '0;
      remaining_q <= '0;
      primed_q    <= 1'b0;
      rs1_addr_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      primed_q    <= primed_d;
      rs1_addr_q  <= rs1_addr_d;
    end
  end

  riscv_regfile_dump_fifo u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (fifo_push),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign o_regfile_rs1_addr = rs1_addr_q;
  assign o_dump_valid       = !fifo_empty;
  assign o_dump_data        = head_entry.data;
  assign o_dump_addr        = head_entry.addr;

endmodule

// File: tb/tb_riscv_regfile_dump.sv
// Scoreboard bench: dut0 emits every register, dut1 skips x0.
module tb_riscv_regfile_dump;
  import riscv_regfile_dump_pkg::*;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [1:0]        start, valid, ready, busy, done;
  logic [4:0]        first [2];
  logic [4:0]        last  [2];
  logic [4:0]        raddr [2];
  logic [4:0]        oaddr [2];
  logic [XLEN-1:0]   rdata [2];
  logic [XLEN-1:0]   odata [2];
  logic [XLEN-1:0]   regs  [32];

  int tests = 0, fails = 0, cyc = 0;
  int pops [2]        = '{0, 0};
  int pops_base [2]   = '{0, 0};
  int done_cnt [2]    = '{0, 0};
  int done_base [2]   = '{0, 0};
  int done_cyc [2]    = '{0, 0};
  int first_valid [2] = '{-1, -1};
  logic [1:0]  stalled = 2'b00;
  logic [36:0] held [2];
  logic [36:0] exp0 [$];
  logic [36:0] exp1 [$];
  bit [3:0]    rpat = 4'b1001;

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  always_comb for (int k = 0; k < 2; k++) rdata[k] = regs[raddr[k]];

  riscv_regfile_dump #(.P_SKIP_X0(1'b0)) dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_dump_start(start[0]),
    .i_dump_first(first[0]), .i_dump_last(last[0]),
    .o_regfile_rs1_addr(raddr[0]), .i_regfile_rs1_data(rdata[0]),
    .o_dump_valid(valid[0]), .i_dump_ready(ready[0]),
    .o_dump_data(odata[0]), .o_dump_addr(oaddr[0]),
    .o_dump_busy(busy[0]), .o_dump_done(done[0])
  );

  riscv_regfile_dump #(.P_SKIP_X0(1'b1)) dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_dump_start(start[1]),
    .i_dump_first(first[1]), .i_dump_last(last[1]),
    .o_regfile_rs1_addr(raddr[1]), .i_regfile_rs1_data(rdata[1]),
    .o_dump_valid(valid[1]), .i_dump_ready(ready[1]),
    .o_dump_data(odata[1]), .o_dump_addr(oaddr[1]),
    .o_dump_busy(busy[1]), .o_dump_done(done[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? exp0.size() : exp1.size();
  endfunction

  function automatic logic [36:0] qpop(input int k);
    if (k == 0) return exp0.pop_front();
    return exp1.pop_front();
  endfunction

  task automatic qpush(input int k, input logic [4:0] a);
    if (k == 0) exp0.push_back({a, regs[a]});
    else        exp1.push_back({a, regs[a]});
  endtask

  // Monitor: pops the scoreboard on every accepted word.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      for (int k = 0; k < 2; k++) begin
        if (done[k]) begin
          done_cnt[k]++;
          done_cyc[k] = cyc;
        end
        if (valid[k] && first_valid[k] < 0) first_valid[k] = cyc;
        if (stalled[k]) check($sformatf("hold%0d", k), {valid[k], oaddr[k], odata[k]}, {1'b1, held[k]});
        if (valid[k] && ready[k]) begin
          pops[k]++;
          if (qsize(k) == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_word%0d: got addr %0d data 0x%0h, none expected", k, oaddr[k], odata[k]);
          end else begin
            check($sformatf("word%0d", k), {oaddr[k], odata[k]}, qpop(k));
          end
        end
        stalled[k] = valid[k] && !ready[k];
        held[k]    = {oaddr[k], odata[k]};
      end
    end else begin
      stalled = 2'b00;
    end
  end

  task automatic start_dump(input int k, input logic [4:0] f, input logic [4:0] l, output int acc);
    pops_base[k]   = pops[k];
    done_base[k]   = done_cnt[k];
    first_valid[k] = -1;
    @(posedge i_clk); #1;
    first[k] = f;
    last[k]  = l;
    start[k] = 1'b1;
    @(posedge i_clk); #1;
    start[k] = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_done(input int k, input bit toggle, input int nwords);
    bit seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(posedge i_clk); #1;
      if (toggle) ready[k] = rpat[c % 4];
      seen = (done_cnt[k] != done_base[k]);
    end
    check($sformatf("done_seen%0d", k), 64'(seen), 64'd1);
    ready[k] = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check($sformatf("done_once%0d", k), 64'(done_cnt[k] - done_base[k]), 64'd1);
    check($sformatf("words%0d", k), 64'(pops[k] - pops_base[k]), 64'(nwords));
    check($sformatf("leftover%0d", k), 64'(qsize(k)), 64'd0);
    check($sformatf("idle%0d", k), {62'd0, busy[k], valid[k]}, 64'd0);
  endtask

  task automatic load_pattern();
    for (int i = 0; i < 32; i++) regs[i] = 32'hC0DE_0000 + 32'(i) * 32'h0001_1111;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc;
    bit hit;
    i_rst = 1'b1;
    start = 2'b00;
    ready = 2'b11;
    for (int k = 0; k < 2; k++) begin
      first[k] = '0;
      last[k]  = '0;
      held[k]  = '0;
    end
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);
    repeat (2) @(posedge i_clk);
    #1;
    for (int k = 0; k < 2; k++)
      check($sformatf("reset%0d", k), {valid[k], busy[k], done[k], oaddr[k], raddr[k], odata[k]}, 64'd0);
    i_rst = 1'b0;

    // Full 0..31 sweep, xN = N, ready held high.
    for (int i = 0; i < 32; i++) qpush(0, 5'(i));
    start_dump(0, 5'd0, 5'd31, acc);
    check("busy_after_start", 64'(busy[0]), 64'd1);
    wait_done(0, 1'b0, 32);
    check("first_valid_lat", 64'(first_valid[0]), 64'(acc + 2));
    check("done_cycle", 64'(done_cyc[0]), 64'(acc + 34));

    // Wrapping range 30..1.
    load_pattern();
    qpush(0, 5'd30);
    qpush(0, 5'd31);
    qpush(0, 5'd0);
    qpush(0, 5'd1);
    start_dump(0, 5'd30, 5'd1, acc);
    wait_done(0, 1'b0, 4);

    // Back-pressure with ready pattern 1,0,0,1.
    for (int i = 8; i <= 15; i++) qpush(0, 5'(i));
    start_dump(0, 5'd8, 5'd15, acc);
    wait_done(0, 1'b1, 8);

    // x0 skipped: 0..2 yields only x1, x2.
    qpush(1, 5'd1);
    qpush(1, 5'd2);
    start_dump(1, 5'd0, 5'd2, acc);
    wait_done(1, 1'b0, 2);

    // x0-only range emits nothing but still completes.
    start_dump(1, 5'd0, 5'd0, acc);
    wait_done(1, 1'b0, 0);

    // Start re-asserted while busy must be ignored.
    for (int i = 10; i <= 13; i++) qpush(0, 5'(i));
    start_dump(0, 5'd10, 5'd13, acc);
    first[0] = 5'd0;
    last[0]  = 5'd31;
    start[0] = 1'b1;
    @(posedge i_clk); #1;
    start[0] = 1'b0;
    wait_done(0, 1'b0, 4);

    // Reset after the third word of a full sweep aborts without done.
    for (int i = 0; i < 32; i++) qpush(0, 5'(i));
    start_dump(0, 5'd0, 5'd31, acc);
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge i_clk); #1;
      hit = (pops[0] - pops_base[0]) >= 3;
    end
    check("third_word", 64'(hit), 64'd1);
    i_rst = 1'b1;
    #1;
    check("abort_outputs", {valid[0], busy[0], done[0], oaddr[0], raddr[0], odata[0]}, 64'd0);
    exp0.delete();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("no_done_on_abort", 64'(done_cnt[0] - done_base[0]), 64'd0);
    qpush(0, 5'd5);
    qpush(0, 5'd6);
    start_dump(0, 5'd5, 5'd6, acc);
    wait_done(0, 1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
